pc_fetch_unit: RTL

Instruction fetch front end for the single-cycle RISC-V core: owns the program counter, issues word reads to instruction memory, buffers returned instructions, and presents them with their PC to the control unit/decode stage over a valid/ready handshake. It is the consumer of the decode side's branch decision: `PCsrc` and the immediate from `ImmSrc` extension redirect fetch to `base + ImmOp`. The fetch unit flushes buffered wrong-path instructions and discards any in-flight memory response.

---
 rtl/pc_fetch_unit_if.sv | 30 +++
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory read port, decode-side handshake and
// branch redirect. The fetch unit takes the master side; memory/decode the slave.
interface pc_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PCsrc;
    logic [ADDR_WIDTH-1:0] redirect_base;
    logic [ADDR_WIDTH-1:0] ImmOp;
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic [6:0]            opcode;
    logic                  instr_ready;
    logic                  misalign;

    modport master (
        input  PCsrc, redirect_base, ImmOp, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, misalign
    );

    modport slave (
        output PCsrc, redirect_base, ImmOp, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, misalign
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem reads, DEPTH-entry
// {pc,instr} buffer, branch redirect with flush. Optional FETCH_ALIGN_CHECK_EN.
module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_unit_if.master bus_io
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  misalign_q;

    logic [ADDR_WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] ins_mem_q [DEPTH];

    logic                  redirect;
    logic                  rvalid;
    logic                  outstanding;
    logic                  resp_keep;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [CNT_W:0]        occ_after;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [ADDR_WIDTH-1:0] target_sum;
    logic [ADDR_WIDTH-1:0] target_d;
    logic                  target_misaligned;

    assign redirect = bus_io.PCsrc;
    assign rvalid   = bus_io.imem_rvalid;

    always_comb begin
        outstanding = (state_q != S_REQ);
        resp_keep   = (state_q == S_WAIT) && rvalid;
        pop         = (count_q != '0) && bus_io.instr_ready;
        // A response landing in the redirect cycle belongs to the wrong path.
        push        = resp_keep && !redirect && !misalign_q;
        occ_after   = {1'b0, count_q} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
        issue       = !rst && !redirect && !misalign_q
                      && ((state_q == S_REQ) || resp_keep)
                      && (occ_after <= OCC_LIMIT);
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        target_sum  = bus_io.redirect_base + bus_io.ImmOp;
`ifdef FETCH_ALIGN_CHECK_EN
        target_d          = target_sum;
        target_misaligned = (target_sum[1:0] != 2'b00);
`else
        target_d          = target_sum & ~ADDR_WIDTH'(3);
        target_misaligned = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            if (redirect) begin
                count_q    <= '0;
                wr_ptr_q   <= rd_ptr_d;
                fetch_pc_q <= target_d;
                misalign_q <= misalign_q | target_misaligned;
                state_q    <= (outstanding && !rvalid) ? S_DROP : S_REQ;
            end else begin
                count_q <= occ_after[CNT_W-1:0];
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
                    req_addr_q <= fetch_pc_q;
                end
                case (state_q)
                    S_REQ:   if (issue) state_q <= S_WAIT;
                    S_WAIT:  if (rvalid) state_q <= issue ? S_WAIT : S_REQ;
                    S_DROP:  if (rvalid) state_q <= S_REQ;
                    default: state_q <= S_REQ;
                endcase
            end
        end
    end

    // Issue throttling guarantees a free slot whenever a kept response arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]  <= req_addr_q;
            ins_mem_q[wr_ptr_q] <= bus_io.imem_rdata;
        end
    end

    assign bus_io.imem_req    = issue;
    assign bus_io.imem_addr   = fetch_pc_q;
    assign bus_io.instr_valid = (count_q != '0);
    assign bus_io.instr       = ins_mem_q[rd_ptr_q];
    assign bus_io.instr_pc    = pc_mem_q[rd_ptr_q];
    assign bus_io.opcode      = ins_mem_q[rd_ptr_q][6:0];
    assign bus_io.misalign    = misalign_q;

endmodule
